// File: rtl/hdmi_info_frame_pkg.sv
// Purpose: constants and enums shared by the HDMI InfoFrame transmit and receive blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hdmi_info_frame_pkg;

    // SPD InfoFrame header bytes
    localparam logic [7:0] SPD_TYPE    = 8'h83;
    localparam logic [7:0] SPD_VERSION = 8'h01;
    localparam logic [7:0] SPD_LENGTH  = 8'd25;

    // Beat index map: 0..2 = HB0..HB2, 3 = PB0, 4..28 = PB1..PB25, 29..30 = PB26..PB27
    localparam logic [4:0] IDX_LAST_HDR    = 5'd2;
    localparam logic [4:0] IDX_FIRST_FIELD = 5'd4;
    localparam logic [4:0] IDX_LAST_SUM    = 5'd28;
    localparam logic [4:0] IDX_LAST        = 5'd30;

    // PB1..PB25 captured as one shift register, PB1 ends up in the top byte
    localparam int SPD_SHADOW_W = 200;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_HEADER    = 2'd1,
        ERR_CHECKSUM  = 2'd2,
        ERR_TRUNCATED = 2'd3
    } info_frame_err_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_SKIP    = 2'd3
    } info_frame_state_e;

endpackage

// File: rtl/info_frame_checksum_acc.sv
// Purpose: 8-bit modulo-256 accumulator with load/add/hold and a zero flag.
// Latency: sum registered one cycle after load/add; zero flag is a decode of the register.
// Backpressure: none; holds when neither load nor add is asserted.
// Ports: clk_i/rst_ni clock and async active-low reset; load_i replaces the sum with
//        byte_i; add_i accumulates byte_i (load wins); zero_o is high when the sum is 0.
module info_frame_checksum_acc (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       add_i,
    input  logic [7:0] byte_i,
    output logic       zero_o
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (load_i) begin
            sum_d = byte_i;
        end else if (add_i) begin
            sum_d = sum_q + byte_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= 8'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign zero_o = (sum_q == 8'd0);

endmodule

// File: rtl/spd_info_frame_receiver.sv
// Purpose: parse SPD InfoFrame bytes, validate header/checksum, commit vendor/product/SDI fields atomically.
// Latency: frame_valid/error pulse one cycle after the final or offending beat; fields update with frame_valid.
// Backpressure: none; accepts one byte per in_valid cycle, in_valid=0 simply stalls.
// Ports: clk_pixel/reset_n clock and async active-low reset; in_valid/in_first/in_byte byte stream
//        (in_first marks HB0); vendor_name/product_description/source_device_information committed
//        fields; info_present sticky; frame_valid/error one-cycle pulses; error_code qualified by error.
module spd_info_frame_receiver
    import hdmi_info_frame_pkg::*;
#(
    parameter bit IGNORE_CHECKSUM = 1'b0
) (
    input  logic         clk_pixel,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic         in_first,
    input  logic [7:0]   in_byte,
    output logic [63:0]  vendor_name,
    output logic [127:0] product_description,
    output logic [7:0]   source_device_information,
    output logic         info_present,
    output logic         frame_valid,
    output logic         error,
    output logic [1:0]   error_code
);

    info_frame_state_e         state_q, state_d;
    logic [4:0]                idx_q, idx_d;
    logic [SPD_SHADOW_W-1:0]   shadow_q, shadow_d;
    logic [63:0]               vendor_q, vendor_d;
    logic [127:0]              product_q, product_d;
    logic [7:0]                sdi_q, sdi_d;
    logic                      present_q, present_d;
    logic                      frame_valid_q, frame_valid_d;
    logic                      error_q, error_d;
    info_frame_err_e           error_code_q, error_code_d;

    logic                      acc_load;
    logic                      acc_add;
    logic                      acc_zero;
    logic                      truncated;
    logic [7:0]                hdr_exp;

    info_frame_checksum_acc u_csum (
        .clk_i  (clk_pixel),
        .rst_ni (reset_n),
        .load_i (acc_load),
        .add_i  (acc_add),
        .byte_i (in_byte),
        .zero_o (acc_zero)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        vendor_d      = vendor_q;
        product_d     = product_q;
        sdi_d         = sdi_q;
        present_d     = present_q;
        frame_valid_d = 1'b0;
        error_d       = 1'b0;
        error_code_d  = ERR_NONE;
        acc_load      = 1'b0;
        acc_add       = 1'b0;
        truncated     = 1'b0;
        hdr_exp       = SPD_VERSION;

        if (in_valid) begin
            if (in_first) begin
                // A new HB0 is always honoured; if a packet was in flight it is abandoned.
                truncated = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
                if (truncated) begin
                    error_d      = 1'b1;
                    error_code_d = ERR_TRUNCATED;
                end
                if (in_byte == SPD_TYPE) begin
                    state_d  = ST_HEADER;
                    idx_d    = 5'd1;
                    acc_load = 1'b1;
                end else begin
                    state_d = ST_SKIP;
                    idx_d   = 5'd0;
                    // Truncation already reported this beat; a bad HB0 adds no second pulse.
                    if (!truncated) begin
                        error_d      = 1'b1;
                        error_code_d = ERR_HEADER;
                    end
                end
            end else begin
                case (state_q)
                    ST_HEADER: begin
                        hdr_exp = (idx_q == 5'd1) ? SPD_VERSION : SPD_LENGTH;
                        if (in_byte != hdr_exp) begin
                            state_d      = ST_SKIP;
                            idx_d        = 5'd0;
                            error_d      = 1'b1;
                            error_code_d = ERR_HEADER;
                        end else begin
                            acc_add = 1'b1;
                            idx_d   = idx_q + 5'd1;
                            if (idx_q == IDX_LAST_HDR) begin
                                state_d = ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        // PB26/PB27 are outside both the checksum and the fields.
                        if (idx_q <= IDX_LAST_SUM) begin
                            acc_add = 1'b1;
                        end
                        if ((idx_q >= IDX_FIRST_FIELD) && (idx_q <= IDX_LAST_SUM)) begin
                            shadow_d = {shadow_q[SPD_SHADOW_W-9:0], in_byte};
                        end
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_IDLE;
                            idx_d   = 5'd0;
                            if (acc_zero || IGNORE_CHECKSUM) begin
                                vendor_d      = shadow_q[199:136];
                                product_d     = shadow_q[135:8];
                                sdi_d         = shadow_q[7:0];
                                present_d     = 1'b1;
                                frame_valid_d = 1'b1;
                            end else begin
                                error_d      = 1'b1;
                                error_code_d = ERR_CHECKSUM;
                            end
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                    default: begin
                        // IDLE and SKIP drop beats that are not HB0.
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= 5'd0;
            shadow_q      <= '0;
            vendor_q      <= '0;
            product_q     <= '0;
            sdi_q         <= '0;
            present_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            error_q       <= 1'b0;
            error_code_q  <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            vendor_q      <= vendor_d;
            product_q     <= product_d;
            sdi_q         <= sdi_d;
            present_q     <= present_d;
            frame_valid_q <= frame_valid_d;
            error_q       <= error_d;
            error_code_q  <= error_code_d;
        end
    end

    assign vendor_name               = vendor_q;
    assign product_description       = product_q;
    assign source_device_information = sdi_q;
    assign info_present              = present_q;
    assign frame_valid               = frame_valid_q;
    assign error                     = error_q;
    assign error_code                = error_code_q;

endmodule

// File: tb/tb_spd_info_frame_receiver.sv
// Purpose: scoreboard bench for spd_info_frame_receiver, checksum-enforcing and checksum-ignoring instances.
// Latency: expected pulses are stamped for the cycle after the beat that causes them.
// Backpressure: random in_valid gaps with junk on in_first/in_byte while invalid.
module tb_spd_info_frame_receiver;

    logic         clk_pixel = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_first;
    logic [7:0]   in_byte;

    logic [63:0]  vn0, vn1;
    logic [127:0] pd0, pd1;
    logic [7:0]   sdi0, sdi1;
    logic         ip0, ip1, fv0, fv1, er0, er1;
    logic [1:0]   ec0, ec1;

    spd_info_frame_receiver #(.IGNORE_CHECKSUM(1'b0)) dut0 (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .in_valid(in_valid), .in_first(in_first),
        .in_byte(in_byte), .vendor_name(vn0), .product_description(pd0),
        .source_device_information(sdi0), .info_present(ip0), .frame_valid(fv0),
        .error(er0), .error_code(ec0));

    spd_info_frame_receiver #(.IGNORE_CHECKSUM(1'b1)) dut1 (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .in_valid(in_valid), .in_first(in_first),
        .in_byte(in_byte), .vendor_name(vn1), .product_description(pd1),
        .source_device_information(sdi1), .info_present(ip1), .frame_valid(fv1),
        .error(er1), .error_code(ec1));

    always #5 clk_pixel = ~clk_pixel;

    int cyc = 0;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int           due;
        bit           is_err;
        logic [1:0]   code;
        logic [63:0]  vn;
        logic [127:0] pd;
        logic [7:0]   sdi;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Last committed values per instance, as seen through the scoreboard
    logic [63:0]  hvn  [2];
    logic [127:0] hpd  [2];
    logic [7:0]   hsdi [2];
    logic         hip  [2];

    // Packet-level reference model: collect bytes of the current packet, judge by the rules
    logic [7:0] pkt[$];
    bit         active = 1'b0;
    logic [7:0] pk [31];

    task automatic push_evt(input int inst, input bit is_err, input logic [1:0] code);
        exp_t e;
        e.due    = cyc + 1;
        e.is_err = is_err;
        e.code   = code;
        e.vn     = '0;
        e.pd     = '0;
        e.sdi    = '0;
        if (!is_err) begin
            for (int i = 0; i < 8; i++)  e.vn = {e.vn[55:0], pkt[4 + i]};
            for (int i = 0; i < 16; i++) e.pd = {e.pd[119:0], pkt[12 + i]};
            e.sdi = pkt[28];
        end
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic model_beat(input bit first, input logic [7:0] b);
        int s;
        int n;
        if (first) begin
            bit trunc;
            trunc = active;
            if (trunc) begin
                push_evt(0, 1'b1, 2'd3);
                push_evt(1, 1'b1, 2'd3);
            end
            pkt.delete();
            pkt.push_back(b);
            if (b != 8'h83) begin
                if (!trunc) begin
                    push_evt(0, 1'b1, 2'd1);
                    push_evt(1, 1'b1, 2'd1);
                end
                active = 1'b0;
            end else begin
                active = 1'b1;
            end
        end else if (active) begin
            pkt.push_back(b);
            n = pkt.size();
            if ((n == 2 && b != 8'h01) || (n == 3 && b != 8'd25)) begin
                push_evt(0, 1'b1, 2'd1);
                push_evt(1, 1'b1, 2'd1);
                active = 1'b0;
            end else if (n == 31) begin
                s = 0;
                for (int i = 0; i < 29; i++) s = (s + int'(pkt[i])) % 256;
                if (s == 0) push_evt(0, 1'b0, 2'd0);
                else        push_evt(0, 1'b1, 2'd2);
                push_evt(1, 1'b0, 2'd0);
                active = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_out(input int inst, input logic fv, input logic er, input logic [1:0] ec,
                             input logic [63:0] vn, input logic [127:0] pd, input logic [7:0] sdi,
                             input logic ip);
        exp_t e;
        bit   have;
        bit   ok;
        if (!fv && !er) return;
        have = (inst == 0) ? (q0.size() > 0) : (q1.size() > 0);
        n_cmp++;
        if (!have) begin
            n_fail++;
            $display("FAIL unexpected_event dut%0d cyc %0d: got fv=%0b err=%0b code=%0d, required no pulse",
                     inst, cyc, fv, er, ec);
            return;
        end
        if (inst == 0) e = q0.pop_front();
        else           e = q1.pop_front();
        ok = (cyc == e.due) && (er == e.is_err) && (fv == !e.is_err) && (!e.is_err || ec == e.code);
        if (!ok) begin
            n_fail++;
            $display("FAIL event dut%0d: got cyc=%0d fv=%0b err=%0b code=%0d, required cyc=%0d fv=%0b err=%0b code=%0d",
                     inst, cyc, fv, er, ec, e.due, !e.is_err, e.is_err, e.code);
        end
        if (!e.is_err) begin
            hvn[inst]  = e.vn;
            hpd[inst]  = e.pd;
            hsdi[inst] = e.sdi;
            hip[inst]  = 1'b1;
        end
        n_cmp++;
        if (vn !== hvn[inst] || pd !== hpd[inst] || sdi !== hsdi[inst] || ip !== hip[inst]) begin
            n_fail++;
            $display("FAIL fields dut%0d: got vn=%h pd=%h sdi=%h ip=%0b, required vn=%h pd=%h sdi=%h ip=%0b",
                     inst, vn, pd, sdi, ip, hvn[inst], hpd[inst], hsdi[inst], hip[inst]);
        end
    endtask

    // Monitor: decoupled from stimulus, samples on the falling edge
    always @(negedge clk_pixel) begin
        if (reset_n === 1'b1) begin
            check_out(0, fv0, er0, ec0, vn0, pd0, sdi0, ip0);
            check_out(1, fv1, er1, ec1, vn1, pd1, sdi1, ip1);
        end
    end

    // All stimulus tasks start and end at posedge + 1
    task automatic idle(input int n);
        repeat (n) begin
            in_valid = 1'b0;
            in_first = 1'($urandom);
            in_byte  = 8'($urandom);
            @(posedge clk_pixel); #1;
        end
    endtask

    task automatic drive(input bit first, input logic [7:0] b);
        in_valid = 1'b1;
        in_first = first;
        in_byte  = b;
        model_beat(first, b);
        @(posedge clk_pixel); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input int gapmax);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, gapmax));
            drive(i == 0, pk[i]);
        end
    endtask

    task automatic fix_csum();
        int s;
        s = 0;
        for (int i = 0; i < 29; i++) if (i != 3) s = s + int'(pk[i]);
        pk[3] = 8'((256 - (s % 256)) % 256);
    endtask

    task automatic rand_pkt();
        pk[0] = 8'h83; pk[1] = 8'h01; pk[2] = 8'h19;
        for (int i = 3; i < 31; i++) pk[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        fix_csum();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vn0"}, {64'd0, vn0}, 128'd0);
        chk({tag, "_pd0"}, pd0, 128'd0);
        chk({tag, "_sdi_ip_fv_err_code0"}, {113'd0, sdi0, ip0, fv0, er0, ec0}, 128'd0);
        chk({tag, "_all1"}, {vn1, 56'd0, sdi1, ip1, fv1, er1, ec1} | pd1, 128'd0);
    endtask

    task automatic reset_mid();
        in_valid = 1'b0;
        @(negedge clk_pixel); #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        active = 1'b0;
        pkt.delete();
        chk("pending_before_reset", 128'(q0.size() + q1.size()), 128'd0);
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            hvn[i] = '0; hpd[i] = '0; hsdi[i] = '0; hip[i] = 1'b0;
        end
        @(posedge clk_pixel); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cyc %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    logic [63:0]  vendor_txt;
    logic [127:0] product_txt;

    initial begin
        for (int i = 0; i < 2; i++) begin
            hvn[i] = '0; hpd[i] = '0; hsdi[i] = '0; hip[i] = 1'b0;
        end
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_byte  = 8'h00;
        repeat (3) @(posedge clk_pixel);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        idle(2);

        // Minimal good packet: PB0 = 0x63, everything else zero
        pk[0] = 8'h83; pk[1] = 8'h01; pk[2] = 8'h19;
        for (int i = 3; i < 31; i++) pk[i] = 8'h00;
        pk[3] = 8'h63;
        send_pkt(31, 0);
        idle(2);
        chk("zero_pkt_present", {127'd0, ip0}, 128'd1);

        // Content packet with text fields
        vendor_txt  = 64'h556E6B6E6F776E00;
        product_txt = "FPGA SPD test rx";
        pk[0] = 8'h83; pk[1] = 8'h01; pk[2] = 8'h19;
        for (int i = 0; i < 8; i++)  pk[4 + i]  = vendor_txt[63 - 8*i -: 8];
        for (int i = 0; i < 16; i++) pk[12 + i] = product_txt[127 - 8*i -: 8];
        pk[28] = 8'h08; pk[29] = 8'hA5; pk[30] = 8'h5A;
        fix_csum();
        send_pkt(31, 0);
        idle(2);
        chk("content_vendor", {64'd0, vn0}, {64'd0, 64'h556E6B6E6F776E00});
        chk("content_sdi", {120'd0, sdi0}, {120'd0, 8'h08});

        // Checksum corruption: dut0 rejects, dut1 accepts
        pk[3] = pk[3] + 8'd1;
        pk[28] = 8'h42;
        send_pkt(31, 0);
        idle(2);
        chk("csum_fields_kept", {120'd0, sdi0}, {120'd0, 8'h08});

        // Header mismatch, then an immediately following good packet
        rand_pkt();
        pk[0] = 8'h82;
        send_pkt(31, 0);
        rand_pkt();
        send_pkt(31, 0);
        idle(2);

        // Truncation at PB10, then the new packet with gaps and again gap-free
        rand_pkt();
        send_pkt(13, 0);
        rand_pkt();
        send_pkt(31, 3);
        send_pkt(31, 0);
        idle(2);

        // Truncation where the interrupting HB0 is itself bad
        rand_pkt();
        send_pkt(8, 1);
        pk[0] = 8'h11;
        send_pkt(31, 0);
        idle(2);

        // Reset at PB15, then a good packet
        rand_pkt();
        send_pkt(18, 1);
        reset_mid();
        rand_pkt();
        send_pkt(31, 1);
        idle(2);

        // Randomised mix
        for (int it = 0; it < 40; it++) begin
            int kind;
            int gm;
            kind = $urandom_range(0, 4);
            gm   = $urandom_range(0, 2);
            rand_pkt();
            case (kind)
                1: pk[3] = pk[3] + 8'($urandom_range(1, 255));
                2: begin
                    int p;
                    p = $urandom_range(0, 2);
                    pk[p] = pk[p] ^ 8'($urandom_range(1, 255));
                end
                3: begin
                    send_pkt($urandom_range(1, 30), gm);
                    rand_pkt();
                end
                4: for (int j = 0; j < 4; j++) begin
                    idle($urandom_range(0, 1));
                    drive(1'b0, 8'($urandom));
                end
                default: ;
            endcase
            send_pkt(31, gm);
        end
        idle(4);

        chk("queue0_drained", 128'(q0.size()), 128'd0);
        chk("queue1_drained", 128'(q1.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
